// File: rtl/slink_rx_lane_merge.sv
// slink_rx_lane_merge: waits for SDS on every active lane, then un-stripes the
// deskewed lane data into full NUM_LANES*DATA_WIDTH words for the link layer.
// With fewer active lanes, several beats are gathered into each output word.
module slink_rx_lane_merge #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            deskew_locked,
  input  logic [2:0]                      active_lanes,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_in,
  input  logic [NUM_LANES-1:0]            rx_data_valid,
  input  logic [NUM_LANES-1:0]            rx_sds_seen,
  output logic [NUM_LANES*DATA_WIDTH-1:0] link_data,
  output logic                            link_valid,
  output logic                            lane_err,
  output logic [1:0]                      merge_state
);

  localparam int LOGN = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
  localparam int KW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int W    = NUM_LANES * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SDS = 2'd1, DATA = 2'd2} state_t;

  state_t               state;
  logic [2:0]           lane_log;   // latched log2 of the active lane count
  logic [KW-1:0]        k;          // beat index within the current word
  logic [W-1:0]         acc;        // partially assembled word
  logic [2:0]           lane_log_in;
  logic [NUM_LANES-1:0] lane_mask;
  logic                 all_valid, any_valid, sds_all, last_beat;
  logic [W-1:0]         merged;

  assign merge_state = state;

  // A requested lane count wider than the link collapses to all lanes.
  assign lane_log_in = (int'(active_lanes) > LOGN) ? 3'(LOGN) : active_lanes;

  // Lanes below L take part; the rest are masked out of every decision.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_mask[i] = (i < (1 << lane_log));
  end

  assign all_valid = &(rx_data_valid | ~lane_mask);
  assign any_valid = |(rx_data_valid & lane_mask);
  assign sds_all   = &(rx_sds_seen | ~lane_mask);
  assign last_beat = (int'(k) == (NUM_LANES >> lane_log) - 1);

  // Drop this beat's lanes into slots k*L .. k*L+L-1 of the accumulator.
  always_comb begin
    merged = acc;
    for (int j = 0; j < NUM_LANES; j++)
      if ((j >> lane_log) == int'(k))
        merged[j*DATA_WIDTH +: DATA_WIDTH] =
          rx_data_in[(j & ((1 << lane_log) - 1))*DATA_WIDTH +: DATA_WIDTH];
  end

  // Merge FSM with registered word output and sticky lane-disagreement flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lane_log   <= '0;
      k          <= '0;
      acc        <= '0;
      link_data  <= '0;
      link_valid <= 1'b0;
      lane_err   <= 1'b0;
    end else begin
      link_valid <= 1'b0;
      if (!enable || !deskew_locked) begin
        // Any partial word is abandoned; it is cleared on the way back out of IDLE.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state    <= WAIT_SDS;
            lane_log <= lane_log_in;
            lane_err <= 1'b0;
            acc      <= '0;
            k        <= '0;
          end
          WAIT_SDS: begin
            if (sds_all) state <= DATA;
          end
          DATA: begin
            if (all_valid) begin
              if (last_beat) begin
                link_data  <= merged;
                link_valid <= 1'b1;
                acc        <= '0;
                k          <= '0;
              end else begin
                acc <= merged;
                k   <= k + 1'b1;
              end
            end else if (any_valid) begin
              lane_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slink_rx_lane_merge.sv
// Directed bench for slink_rx_lane_merge: stimulus pushes expected words into a
// queue, an independent monitor pops and compares on every link_valid strobe.
module tb_slink_rx_lane_merge;

  logic        clk = 1'b0;
  logic        reset, enable, deskew_locked;
  logic [2:0]  active_lanes;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_data_valid, rx_sds_seen;
  logic [31:0] link_data;
  logic        link_valid, lane_err;
  logic [1:0]  merge_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  slink_rx_lane_merge #(.NUM_LANES(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .deskew_locked(deskew_locked),
    .active_lanes(active_lanes), .rx_data_in(rx_data_in),
    .rx_data_valid(rx_data_valid), .rx_sds_seen(rx_sds_seen),
    .link_data(link_data), .link_valid(link_valid), .lane_err(lane_err),
    .merge_state(merge_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!reset && link_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got=0x%0h expected=no strobe", link_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (link_data !== e) begin
          failures++;
          $display("FAIL strobe_data got=0x%0h expected=0x%0h", link_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Bring the block from IDLE through WAIT_SDS into DATA.
  task automatic start(input logic [2:0] al);
    enable = 1'b1; deskew_locked = 1'b1; active_lanes = al;
    rx_sds_seen = 4'h0; rx_data_valid = 4'h0;
    cyc();
    rx_sds_seen = 4'hF;
    cyc();
    rx_sds_seen = 4'h0;
  endtask

  task automatic beat(input logic [3:0] v, input logic [31:0] d,
                      input bit push, input logic [31:0] e);
    rx_data_valid = v; rx_data_in = d;
    cyc();
    if (push) exp_q.push_back(e);
    rx_data_valid = 4'h0;
  endtask

  task automatic drop();
    enable = 1'b0; rx_data_valid = 4'h0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; deskew_locked = 1'b0; active_lanes = 3'd0;
    rx_data_in = '0; rx_data_valid = '0; rx_sds_seen = '0;
    cyc(); cyc();
    chk("reset_state", 32'(merge_state), 32'd0);
    chk("reset_data", link_data, 32'h0);
    chk("reset_valid", 32'(link_valid), 32'd0);
    chk("reset_err", 32'(lane_err), 32'd0);
    reset = 1'b0;
    cyc();

    // 1) four lanes, one word per valid cycle
    start(3'd2);
    chk("t1_state_data", 32'(merge_state), 32'd2);
    beat(4'hF, 32'h44332211, 1'b1, 32'h44332211);
    rx_data_valid = 4'hF; rx_data_in = 32'h88776655; cyc(); exp_q.push_back(32'h88776655);
    chk("t1_b2b_strobe", 32'(link_valid), 32'd1);
    rx_data_in = 32'hCCBBAA99; cyc(); exp_q.push_back(32'hCCBBAA99);
    rx_data_valid = 4'h0; cyc();
    chk("t1_hold_data", link_data, 32'hCCBBAA99);
    chk("t1_err", 32'(lane_err), 32'd0);

    // 2) one lane, four beats per word; other lanes carry junk
    drop();
    start(3'd0);
    beat(4'b1011, 32'hDEADBEA0, 1'b0, 32'h0);
    beat(4'b1011, 32'h5A5A5AA1, 1'b0, 32'h0);
    chk("t2_no_early_strobe", 32'(link_valid), 32'd0);
    beat(4'b1011, 32'h123456A2, 1'b0, 32'h0);
    beat(4'b1011, 32'hFFFFFFA3, 1'b1, 32'hA3A2A1A0);
    cyc();

    // 3) two lanes with a hole in the middle
    drop();
    start(3'd1);
    beat(4'b0011, 32'hEEEEB1B0, 1'b0, 32'h0);
    beat(4'b1100, 32'h77770000, 1'b0, 32'h0);
    beat(4'b0011, 32'h9999B3B2, 1'b1, 32'hB3B2B1B0);
    cyc();
    chk("t3_hole_no_err", 32'(lane_err), 32'd0);

    // 4) lane disagreement: beat dropped, k held, lane_err sticky until re-enable
    drop();
    start(3'd2);
    beat(4'b0111, 32'h11111111, 1'b0, 32'h0);
    chk("t4_err_set", 32'(lane_err), 32'd1);
    chk("t4_no_strobe", 32'(link_valid), 32'd0);
    beat(4'hF, 32'h0D0C0B0A, 1'b1, 32'h0D0C0B0A);
    enable = 1'b0; cyc();
    chk("t4_idle", 32'(merge_state), 32'd0);
    chk("t4_err_sticky", 32'(lane_err), 32'd1);
    enable = 1'b1; cyc();
    chk("t4_err_cleared", 32'(lane_err), 32'd0);

    // 5) partial word discarded on loss of lock
    drop();
    start(3'd0);
    beat(4'h1, 32'h00000011, 1'b0, 32'h0);
    beat(4'h1, 32'h00000022, 1'b0, 32'h0);
    deskew_locked = 1'b0; cyc();
    chk("t5_idle", 32'(merge_state), 32'd0);
    start(3'd0);
    beat(4'h1, 32'h00000055, 1'b0, 32'h0);
    beat(4'h1, 32'h00000066, 1'b0, 32'h0);
    beat(4'h1, 32'h00000077, 1'b0, 32'h0);
    beat(4'h1, 32'h00000088, 1'b1, 32'h88776655);
    cyc();

    // clamp: active_lanes beyond the link width acts as all lanes
    drop();
    start(3'd7);
    beat(4'hF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
    cyc();

    // 6) data before SDS on every lane, then async reset mid-DATA
    drop();
    enable = 1'b1; deskew_locked = 1'b1; active_lanes = 3'd2; cyc();
    rx_sds_seen = 4'b0111; rx_data_valid = 4'hF; rx_data_in = 32'h0BADF00D;
    cyc(); cyc();
    chk("t6_wait_sds", 32'(merge_state), 32'd1);
    rx_sds_seen = 4'hF; rx_data_valid = 4'h0; cyc();
    rx_sds_seen = 4'h0;
    chk("t6_data", 32'(merge_state), 32'd2);
    beat(4'hF, 32'h04030201, 1'b1, 32'h04030201);
    cyc();
    beat(4'hF, 32'h08070605, 1'b0, 32'h0);
    reset = 1'b1; #1;
    chk("t6_rst_valid", 32'(link_valid), 32'd0);
    chk("t6_rst_data", link_data, 32'h0);
    chk("t6_rst_state", 32'(merge_state), 32'd0);
    cyc(); reset = 1'b0; cyc(); cyc();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
